// File: rtl/serial_parity_frame_rx_pkg.sv
// Shared constants for the serial parity frame receiver: FSM encoding, default width, line idle level.
package serial_parity_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int   DEFAULT_FRAME_BITS = 3;
  localparam logic LINE_IDLE          = 1'b1;

endpackage

// File: rtl/serial_parity_frame_rx_even_parity_check.sv
// Combinational N-input even-parity checker (XNOR reduction); zero latency, no flow control.
module even_parity_check #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] data,
  output logic             even
);

  assign even = ~(^data);

endmodule

// File: rtl/serial_parity_frame_rx.sv
// Start/stop framed serial receiver that presents FRAME_BITS words with an even-parity verdict; 1 clk from stop strobe to out_valid.
// A held word blocks new ones (they are dropped and overrun is set); ERR_COUNT_EN adds a saturating err_count.
module serial_parity_frame_rx
  import serial_parity_frame_rx_pkg::*;
#(
  parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_en,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  parity_ok,
  output logic                  frame_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
`ifdef ERR_COUNT_EN
  ,
  output logic [ERR_W-1:0]      err_count
`endif
);

  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  state_t                  state, nxt_state;
  logic [IDX_W-1:0]        idx, nxt_idx;
  logic [FRAME_BITS-1:0]   shreg, nxt_shreg;
  logic                    complete;
  logic                    stop_bad;
  logic                    shreg_even;
  logic                    out_free;
  logic                    load;
  logic                    drop;

  even_parity_check #(.WIDTH(FRAME_BITS)) u_parity (
    .data (shreg),
    .even (shreg_even)
  );

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_shreg = shreg;
    complete  = 1'b0;
    stop_bad  = 1'b0;
    if (bit_en) begin
      case (state)
        ST_IDLE: begin
          if (din != LINE_IDLE) begin
            nxt_state = ST_DATA;
            nxt_idx   = '0;
          end
        end
        ST_DATA: begin
          nxt_shreg = {shreg[FRAME_BITS-2:0], din};
          if (idx == LAST_IDX) begin
            nxt_state = ST_STOP;
          end else begin
            nxt_idx = idx + IDX_W'(1);
          end
        end
        ST_STOP: begin
          // A low stop bit is a framing error, never a start bit.
          complete  = 1'b1;
          stop_bad  = (din != LINE_IDLE);
          nxt_state = ST_IDLE;
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  assign out_free = !out_valid || out_ready;
  assign load     = complete && out_free;
  assign drop     = complete && !out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      shreg     <= '0;
      frame     <= '0;
      parity_ok <= 1'b0;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      shreg <= nxt_shreg;
      if (load) begin
        frame     <= shreg;
        parity_ok <= shreg_even;
        frame_err <= stop_bad;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (load && (!shreg_even || stop_bad) && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_serial_parity_frame_rx.sv
// Directed self-checking bench for serial_parity_frame_rx with FRAME_BITS=3.
module tb_serial_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       din;
  logic [2:0] frame;
  logic       parity_ok;
  logic       frame_err;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
`ifdef ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int total = 0;
  int bad   = 0;

  serial_parity_frame_rx #(.FRAME_BITS(3), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .din       (din),
    .frame     (frame),
    .parity_ok (parity_ok),
    .frame_err (frame_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
`ifdef ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    bit_en = 1'b1;
    din    = b;
    tick();
    bit_en = 1'b0;
    din    = 1'b1;
  endtask

  task automatic send_frame(input logic [2:0] d, input logic stop_b);
    strobe(1'b0);
    for (int i = 2; i >= 0; i--) strobe(d[i]);
    strobe(stop_b);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (frame !== 3'b000) begin bad++; $display("FAIL reset_frame got=%b exp=000", frame); end
    total++; if (parity_ok !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b exp=0", parity_ok); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
`ifdef ERR_COUNT_EN
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
`endif
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      strobe(1'b1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, out_valid); end
    end
    total++; if (frame !== 3'b000) begin bad++; $display("FAIL idle_frame got=%b exp=000", frame); end
    total++; if (parity_ok !== 1'b0) begin bad++; $display("FAIL idle_parity got=%b exp=0", parity_ok); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL idle_overrun got=%b exp=0", overrun); end
`ifdef ERR_COUNT_EN
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL idle_errcnt got=%0d exp=0", err_count); end
`endif
  endtask

  task automatic test_good_frame();
    out_ready = 1'b1;
    send_frame(3'b011, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b exp=1", out_valid); end
    total++; if (frame !== 3'b011) begin bad++; $display("FAIL good_frame got=%b exp=011", frame); end
    total++; if (parity_ok !== 1'b1) begin bad++; $display("FAIL good_parity got=%b exp=1", parity_ok); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL good_ferr got=%b exp=0", frame_err); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL good_valid_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_parity_err();
    send_frame(3'b010, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL perr_valid got=%b exp=1", out_valid); end
    total++; if (frame !== 3'b010) begin bad++; $display("FAIL perr_frame got=%b exp=010", frame); end
    total++; if (parity_ok !== 1'b0) begin bad++; $display("FAIL perr_parity got=%b exp=0", parity_ok); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL perr_ferr got=%b exp=0", frame_err); end
`ifdef ERR_COUNT_EN
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL perr_errcnt got=%0d exp=1", err_count); end
`endif
    tick();
  endtask

  task automatic test_both_err();
    send_frame(3'b111, 1'b0);
    total++; if (frame !== 3'b111) begin bad++; $display("FAIL both_frame got=%b exp=111", frame); end
    total++; if (parity_ok !== 1'b0) begin bad++; $display("FAIL both_parity got=%b exp=0", parity_ok); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL both_ferr got=%b exp=1", frame_err); end
`ifdef ERR_COUNT_EN
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL both_errcnt got=%0d exp=2", err_count); end
`endif
    strobe(1'b1);
    send_frame(3'b101, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL recover_valid got=%b exp=1", out_valid); end
    total++; if (frame !== 3'b101) begin bad++; $display("FAIL recover_frame got=%b exp=101", frame); end
    total++; if (parity_ok !== 1'b1) begin bad++; $display("FAIL recover_parity got=%b exp=1", parity_ok); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL recover_ferr got=%b exp=0", frame_err); end
`ifdef ERR_COUNT_EN
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL recover_errcnt got=%0d exp=2", err_count); end
`endif
    tick();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_frame(3'b011, 1'b1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    send_frame(3'b100, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
    total++; if (frame !== 3'b011) begin bad++; $display("FAIL ovr_held_frame got=%b exp=011", frame); end
    total++; if (parity_ok !== 1'b1) begin bad++; $display("FAIL ovr_held_parity got=%b exp=1", parity_ok); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
`ifdef ERR_COUNT_EN
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL ovr_errcnt got=%0d exp=2", err_count); end
`endif
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_no_second cyc=%0d got=%b exp=0", i, out_valid); end
      tick();
    end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_midframe();
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    pulse_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
    strobe(1'b1);
    strobe(1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_partial got=%b exp=0", out_valid); end
    send_frame(3'b110, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid2 got=%b exp=1", out_valid); end
    total++; if (frame !== 3'b110) begin bad++; $display("FAIL mid_frame got=%b exp=110", frame); end
    total++; if (parity_ok !== 1'b1) begin bad++; $display("FAIL mid_parity got=%b exp=1", parity_ok); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_frame(3'b011, 1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    out_ready = 1'b1;
    strobe(1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
    total++; if (frame !== 3'b110) begin bad++; $display("FAIL b2b_frame got=%b exp=110", frame); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", out_valid); end
`ifdef ERR_COUNT_EN
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL b2b_errcnt got=%0d exp=0", err_count); end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    bit_en    = 1'b0;
    din       = 1'b1;
    out_ready = 1'b1;
    test_reset();
    test_idle();
    test_good_frame();
    test_parity_err();
    test_both_err();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
